// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit: S1 captures operands, S2 holds the
// computed result plus zero/parity/all-ones flags for the writeback consumer.
module logic_unit_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic             all_ones
);

    function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] sel,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (sel)
            3'b000:  r = ~(x & y);
            3'b001:  r = x & y;
            3'b010:  r = x | y;
            3'b011:  r = ~(x | y);
            3'b100:  r = x ^ y;
            3'b101:  r = ~(x ^ y);
            3'b110:  r = ~x;
            3'b111:  r = x;
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic parity_of(input logic [WIDTH-1:0] x);
        return ^x;
    endfunction

    logic             s1_valid_q;
    logic [2:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_result_q;
    logic             s2_zero_q;
    logic             s2_parity_q;
    logic             s2_all_ones_q;

    logic             s2_adv_s;
    logic             s1_adv_s;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic             parity_d;
    logic             all_ones_d;

    // Handshake advance terms and the S2 next-state computation from S1 contents.
    always_comb begin
        s2_adv_s   = !s2_valid_q || out_ready;
        s1_adv_s   = !s1_valid_q || s2_adv_s;
        result_d   = logic_op(s1_op_q, s1_a_q, s1_b_q);
        zero_d     = (result_d == {WIDTH{1'b0}});
        parity_d   = parity_of(result_d);
        all_ones_d = (result_d == {WIDTH{1'b1}});
    end

    // Valid bits and S2 result/flag registers; reset discards in-flight work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_result_q   <= {WIDTH{1'b0}};
            s2_zero_q     <= 1'b1;
            s2_parity_q   <= 1'b0;
            s2_all_ones_q <= 1'b0;
        end else begin
            if (s1_adv_s) begin
                s1_valid_q <= in_valid;
            end
            if (s2_adv_s) begin
                s2_valid_q    <= s1_valid_q;
                s2_result_q   <= result_d;
                s2_zero_q     <= zero_d;
                s2_parity_q   <= parity_d;
                s2_all_ones_q <= all_ones_d;
            end
        end
    end

    // S1 operand capture; data is don't-care while the stage is invalid.
    always_ff @(posedge clk) begin
        if (s1_adv_s) begin
            s1_op_q <= op;
            s1_a_q  <= a;
            s1_b_q  <= b;
        end
    end

    assign in_ready  = s1_adv_s;
    assign out_valid = s2_valid_q;
    assign result    = s2_result_q;
    assign zero      = s2_zero_q;
    assign parity    = s2_parity_q;
    assign all_ones  = s2_all_ones_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench: directed tests on an 8-bit unit, random stress on 1- and 64-bit units.
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // WIDTH=8 instance (directed)
    logic       iv8, ir8, ov8, or8, z8, p8, ao8;
    logic [2:0] op8;
    logic [7:0] a8, b8, r8;
    // WIDTH=1 instance (stress)
    logic       iv1, ir1, ov1, or1, z1, p1, ao1;
    logic [2:0] op1;
    logic [0:0] a1, b1, r1;
    // WIDTH=64 instance (stress)
    logic        iv64, ir64, ov64, or64, z64, p64, ao64;
    logic [2:0]  op64;
    logic [63:0] a64, b64, r64;

    logic [66:0] sb_q [3][$];
    logic        hold_q [3];
    logic [63:0] hold_res [3];

    logic_unit_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .result(r8), .zero(z8), .parity(p8), .all_ones(ao8));
    logic_unit_pipe #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .result(r1), .zero(z1), .parity(p1), .all_ones(ao1));
    logic_unit_pipe #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .op(op64), .a(a64), .b(b64),
        .out_valid(ov64), .out_ready(or64), .result(r64), .zero(z64), .parity(p64), .all_ones(ao64));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mask_of(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] ref_op(input int w, input logic [2:0] o,
                                           input logic [63:0] x, input logic [63:0] y);
        logic [63:0] r;
        case (o)
            3'd0: r = ~(x & y);
            3'd1: r = x & y;
            3'd2: r = x | y;
            3'd3: r = ~(x | y);
            3'd4: r = x ^ y;
            3'd5: r = ~(x ^ y);
            3'd6: r = ~x;
            default: r = x;
        endcase
        return r & mask_of(w);
    endfunction

    task automatic mon(input int id, input int w, input logic rst, input logic iv, input logic ir,
                       input logic ov, input logic ordy, input logic [2:0] o,
                       input logic [63:0] x, input logic [63:0] y, input logic [63:0] res,
                       input logic z, input logic p, input logic ao);
        logic [66:0] e;
        logic [63:0] r;
        if (!rst) begin
            sb_q[id].delete();
            hold_q[id] = 1'b0;
        end else begin
            if (hold_q[id]) begin
                chk($sformatf("w%0d_hold_valid", w), {63'd0, ov}, 64'd1);
                chk($sformatf("w%0d_hold_res", w), res, hold_res[id]);
            end
            if (ov && ordy) begin
                if (sb_q[id].size() == 0) begin
                    chk($sformatf("w%0d_spurious", w), 64'd1, 64'd0);
                end else begin
                    e = sb_q[id].pop_front();
                    chk($sformatf("w%0d_res", w), res, e[63:0]);
                    chk($sformatf("w%0d_flags", w), {61'd0, z, p, ao}, {61'd0, e[64], e[65], e[66]});
                end
            end
            if (iv && ir) begin
                r = ref_op(w, o, x, y);
                sb_q[id].push_back({(r == mask_of(w)), ^r, (r == 64'd0), r});
            end
            hold_q[id]   = ov && !ordy;
            hold_res[id] = res;
        end
    endtask

    // Scoreboard monitors, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        mon(0, 8, rst_n, iv8, ir8, ov8, or8, op8, {56'd0, a8}, {56'd0, b8}, {56'd0, r8}, z8, p8, ao8);
        mon(1, 1, rst_n, iv1, ir1, ov1, or1, op1, {63'd0, a1}, {63'd0, b1}, {63'd0, r1}, z1, p1, ao1);
        mon(2, 64, rst_n, iv64, ir64, ov64, or64, op64, a64, b64, r64, z64, p64, ao64);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        iv8 = 1'b1; op8 = o; a8 = x; b8 = y;
    endtask

    task automatic directed();
        logic [2:0] ops [4];
        logic [7:0] as [4];
        logic [7:0] bs [4];
        logic [7:0] rs [4];
        ops = '{3'd4, 3'd3, 3'd6, 3'd7};
        as  = '{8'hAA, 8'h00, 8'h01, 8'h80};
        bs  = '{8'hAA, 8'h00, 8'hFF, 8'h00};
        rs  = '{8'h00, 8'hFF, 8'hFE, 8'h80};
        // single NAND, latency 2
        tick; drive8(3'd0, 8'hF0, 8'h3C); or8 = 1'b1;
        sample; chk("t1_accept", {63'd0, ir8}, 64'd1);
        tick; iv8 = 1'b0;
        sample; chk("t1_lat1_ov", {63'd0, ov8}, 64'd0);
        tick; sample;
        chk("t1_lat2_ov", {63'd0, ov8}, 64'd1);
        chk("t1_res", {56'd0, r8}, 64'hCF);
        chk("t1_flags", {61'd0, z8, p8, ao8}, 64'd0);
        tick; sample; chk("t1_lat3_ov", {63'd0, ov8}, 64'd0);
        // back-to-back
        for (int i = 0; i < 7; i++) begin
            tick;
            if (i < 4) drive8(ops[i], as[i], bs[i]);
            else iv8 = 1'b0;
            sample;
            chk("b2b_ov", {63'd0, ov8}, (i >= 2 && i <= 5) ? 64'd1 : 64'd0);
            if (i >= 2 && i <= 5) chk("b2b_res", {56'd0, r8}, {56'd0, rs[i-2]});
        end
        // backpressure
        or8 = 1'b0;
        tick; drive8(3'd1, 8'h0F, 8'hFF);
        sample; chk("bp_acc0", {63'd0, ir8}, 64'd1);
        tick; drive8(3'd2, 8'h10, 8'h01);
        sample; chk("bp_acc1", {63'd0, ir8}, 64'd1);
        tick; drive8(3'd5, 8'h00, 8'h00);
        sample; chk("bp_full_ir", {63'd0, ir8}, 64'd0);
        chk("bp_ov", {63'd0, ov8}, 64'd1);
        chk("bp_res", {56'd0, r8}, 64'h0F);
        tick; sample;
        chk("bp_full_ir2", {63'd0, ir8}, 64'd0);
        chk("bp_res2", {56'd0, r8}, 64'h0F);
        tick; or8 = 1'b1;
        sample; chk("bp_acc2", {63'd0, ir8}, 64'd1);
        chk("bp_out0", {56'd0, r8}, 64'h0F);
        tick; iv8 = 1'b0;
        sample; chk("bp_ov1", {63'd0, ov8}, 64'd1); chk("bp_out1", {56'd0, r8}, 64'h11);
        tick; sample; chk("bp_ov2", {63'd0, ov8}, 64'd1); chk("bp_out2", {56'd0, r8}, 64'hFF);
        tick; sample; chk("bp_ov3", {63'd0, ov8}, 64'd0);
        // simultaneous drain/fill
        or8 = 1'b0;
        tick; drive8(3'd0, 8'h00, 8'h00); sample;
        tick; drive8(3'd1, 8'hFF, 8'hFF); sample;
        tick; iv8 = 1'b0;
        sample; chk("df_full_ir", {63'd0, ir8}, 64'd0);
        tick; drive8(3'd2, 8'h01, 8'h02); or8 = 1'b1;
        sample; chk("df_accept", {63'd0, ir8}, 64'd1); chk("df_ov0", {63'd0, ov8}, 64'd1);
        tick; iv8 = 1'b0;
        sample; chk("df_nobubble", {63'd0, ov8}, 64'd1);
        tick; sample; chk("df_ov2", {63'd0, ov8}, 64'd1); chk("df_res2", {56'd0, r8}, 64'h03);
        tick; sample; chk("df_ov3", {63'd0, ov8}, 64'd0);
        // reset with two in flight
        or8 = 1'b0;
        tick; drive8(3'd4, 8'h12, 8'h34); sample;
        tick; drive8(3'd2, 8'h55, 8'hAA); sample;
        chk("rst_acc", {63'd0, ir8}, 64'd1);
        tick; iv8 = 1'b0; rst_n = 1'b0; sample;
        tick; rst_n = 1'b1; sample;
        chk("rst_ov", {63'd0, ov8}, 64'd0);
        chk("rst_res", {56'd0, r8}, 64'd0);
        chk("rst_zero", {63'd0, z8}, 64'd1);
        chk("rst_ir", {63'd0, ir8}, 64'd1);
        or8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick; sample; chk("rst_no_ghost", {63'd0, ov8}, 64'd0);
        end
    endtask

    task automatic stress();
        for (int i = 0; i < 800; i++) begin
            tick;
            iv1  = 1'($urandom_range(0, 1));
            op1  = 3'($urandom_range(0, 7));
            a1   = 1'($urandom_range(0, 1));
            b1   = 1'($urandom_range(0, 1));
            or1  = ($urandom_range(0, 3) != 0);
            iv64 = 1'($urandom_range(0, 1));
            op64 = 3'($urandom_range(0, 7));
            a64  = {32'($urandom), 32'($urandom)};
            b64  = ($urandom_range(0, 7) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
            or64 = ($urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iv8 = 1'b0; op8 = 3'd0; a8 = 8'd0; b8 = 8'd0; or8 = 1'b1;
        iv1 = 1'b0; op1 = 3'd0; a1 = 1'b0; b1 = 1'b0; or1 = 1'b1;
        iv64 = 1'b0; op64 = 3'd0; a64 = 64'd0; b64 = 64'd0; or64 = 1'b1;
        repeat (3) tick;
        rst_n = 1'b1;
        sample;
        chk("reset_ov", {63'd0, ov8}, 64'd0);
        chk("reset_res", {56'd0, r8}, 64'd0);
        chk("reset_flags", {61'd0, z8, p8, ao8}, 64'd4);
        chk("reset_ir", {63'd0, ir8}, 64'd1);
        chk("reset_ov64", {63'd0, ov64}, 64'd0);
        fork
            directed();
            stress();
        join
        tick;
        iv8 = 1'b0; iv1 = 1'b0; iv64 = 1'b0;
        or8 = 1'b1; or1 = 1'b1; or64 = 1'b1;
        repeat (6) tick;
        sample;
        chk("drain_w8", 64'(sb_q[0].size()), 64'd0);
        chk("drain_w1", 64'(sb_q[1].size()), 64'd0);
        chk("drain_w64", 64'(sb_q[2].size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined bitwise logic unit for the processor datapath. It generalises the two-input NAND gate into a WIDTH-bit unit with eight selectable operations and result flags. It has a two-stage valid/ready pipeline so it can sit between the operand-fetch and writeback stages and tolerate writeback stalls.

Parameters:
WIDTH, 16, operand/result width in bits (legal 1..64)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  operand transaction present
in_ready  output  1  unit can accept a transaction this cycle
op  input  3  operation select, sampled with operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result transaction present
out_ready  input  1  consumer accepts result this cycle
result  output  WIDTH  operation result
zero  output  1  result == 0
parity  output  1  XOR-reduction of result (1 = odd number of ones)
all_ones  output  1  result == all ones

Behaviour:
- Op encoding:
  - 000 NAND ~(a&b)
  - 001 AND
  - 010 OR
  - 011 NOR
  - 100 XOR
  - 101 XNOR
  - 110 NOT a (b ignored)
  - 111 PASS a (b ignored)
- Stage 1 (S1): registers a, b, op and s1_valid on accept (in_valid && in_ready).
- Stage 2 (S2): computes the op from S1 contents and registers result, zero, parity, all_ones and s2_valid.
- Handshake rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready; no comb path from in_valid)
  - S2 loads when s2_adv: takes S1 contents and s2_valid <= s1_valid.
  - S1 loads when s1_adv: s1_valid <= in_valid.
- Outputs:
  - out_valid = s2_valid.
  - result and the three flags come directly from S2 registers. They are stable while out_valid && !out_ready.
- Latency: transaction accepted in cycle 0 → out_valid=1 in cycle 2 with matching result (no backpressure). Throughput is one transaction per cycle while out_ready=1.
- Backpressure:
  - With out_ready=0, at most 2 transactions are held (S1 + S2); in_ready falls to 0 once both are full.
  - No transaction is dropped, duplicated or reordered.
  - When out_ready rises, S2 drains and S1 moves to S2 in the same edge. in_ready=1 in that same cycle, so a simultaneous new accept fills S1.
- out_valid may not drop without a completed handshake (out_valid && out_ready).
- Data registers may be left unreset. Invalid stages carry don't-care data.
- Reset (rst_n=0 at a rising edge):
  - s1_valid=0, s2_valid=0
  - out_valid=0, result=0, zero=1, parity=0, all_ones=0
  - in_ready=1 on the first cycle after reset deasserts
  - Reset mid-operation discards all in-flight transactions; no result from them ever appears.
- in_valid is ignored while rst_n=0.
- Width rules:
  - All ops are pure bitwise on WIDTH bits; no carries.
  - zero and all_ones are mutually exclusive for all WIDTH ≥ 1.
  - For WIDTH=1, parity == result.

Test Plan:
- WIDTH=8, op=000, a=0xF0, b=0x3C, out_ready=1:
  - result=0xCF, zero=0, parity=0, all_ones=0
  - out_valid exactly 2 cycles after accept, for 1 cycle
- Back-to-back ops with out_ready=1, one per cycle:
  - XOR 0xAA,0xAA → 0x00, zero=1, parity=0
  - NOR 0x00,0x00 → 0xFF, all_ones=1, parity=0
  - NOT a=0x01, b=0xFF → 0xFE, parity=1
  - PASS a=0x80 → 0x80, parity=1
  - Results in order on consecutive cycles.
- Backpressure: out_ready=0, offer 3 transactions (AND 0x0F/0xFF, OR 0x10/0x01, XNOR 0x00/0x00):
  - First two accepted; in_ready=0 while the third is held.
  - out_valid=1 holding 0x0F stable.
  - Raise out_ready: 0x0F, 0x11, 0xFF delivered in order, with no gaps after the third is accepted.
- Simultaneous drain/fill: pipeline full, out_ready=1 and in_valid=1 in the same cycle → accept occurs, out_valid stays 1, no bubble.
- Reset mid-op: two transactions in flight, rst_n=0 for 1 cycle:
  - out_valid=0, result=0, zero=1, in_ready=1 after release
  - Neither lost transaction ever appears at the output.
- Random stress, WIDTH=1 and WIDTH=64: random ops, operands, in_valid and out_ready; check against a reference-model queue for data, flags and ordering.
